// File: rtl/sram22_ctrl_pkg.sv
// Shared widths, FSM state and requester-id types for the SRAM22 64x32 controller.
package sram22_ctrl_pkg;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 6;
  localparam int SRAM_DEPTH      = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/sram22_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, the priority pointer is registered.
module sram22_rr_arb2
  import sram22_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t rr_ptr_q, rr_ptr_d;
  logic    any_grant;

  always_comb begin
    grant_id  = (valid == 2'b11) ? rr_ptr_q : valid[1];
    any_grant = advance && (|valid);
    grant     = any_grant ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    // The winner yields priority to the other side; idle cycles keep the pointer.
    rr_ptr_d  = any_grant ? ~grant_id : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sram22_64x32_arb2.sv
// SRAM22 64x32 controller: post-reset zero fill, then round-robin sharing between two
// requesters with tagged, fixed 1-cycle read responses.
module sram22_64x32_arb2
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_din,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    init_done,
  output logic                    sram_we,
  output logic                    sram_wmask,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_din,
  input  logic [DATA_WIDTH-1:0]   sram_dout
);

  localparam state_t RST_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_done_q;
  logic                  rsp_valid_q;
  req_id_t               rsp_id_q;

  logic [1:0]            grant;
  req_id_t               grant_id;
  logic                  advance;
  logic                  init_last;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  assign advance   = rst_n && (state_q == ST_RUN);
  assign init_last = &init_addr_q;
  assign sel_addr  = grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_din   = grant_id ? req_din[2*DATA_WIDTH-1:DATA_WIDTH] : req_din[DATA_WIDTH-1:0];
  assign rd_accept = (|grant) && !req_we[grant_id];

  sram22_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (req_valid),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Macro pins are forced quiet while reset is held so nothing is written.
  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        sram_we    = 1'b1;
        sram_wmask = 1'b1;
        sram_addr  = init_addr_q;
      end else if (|grant) begin
        sram_we    = req_we[grant_id];
        sram_wmask = req_we[grant_id];
        sram_addr  = sel_addr;
        sram_din   = sel_din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rd_accept;
      if (rd_accept) begin
        rsp_id_q <= grant_id;
      end
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_last) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = sram_dout;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram22_64x32_arb2.sv
// Directed bench for sram22_64x32_arb2 with a behavioural SRAM22 macro model.
module tb_sram22_64x32_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [11:0] req_addr;
  logic [63:0] req_din;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        init_done;
  logic        sram_we;
  logic        sram_wmask;
  logic [5:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram22_64x32_arb2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .init_done  (init_done),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Macro model: starts with non-zero garbage so the fill is observable.
  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hBAD0_0000 + k;
      mem_loaded <= 1'b1;
      sram_dout  <= 32'h0;
    end else begin
      if (sram_we && sram_wmask) mem[sram_addr] <= sram_din;
      if (!sram_we) sram_dout <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [5:0]  a0;
    logic [5:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ready;
    logic        swe;
    logic [5:0]  saddr;
    logic [31:0] sdin;
    logic        rv;
    logic        rid;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [5:0] a0,
                       input logic [5:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_din   = {d1, d0};
  endtask

  task automatic add(input logic [1:0] v, input logic [1:0] we, input logic [5:0] a0,
                     input logic [5:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] rdy, input logic swe, input logic [5:0] sa,
                     input logic [31:0] sd, input logic rv, input logic rid,
                     input logic [31:0] rdata);
    vecs.push_back('{v, we, a0, a1, d0, d1, rdy, swe, sa, sd, rv, rid, rdata});
  endtask

  // Called at negedge+1; returns at the following negedge+1.
  task automatic init_fill(input int n);
    for (int i = 0; i < n; i++) begin
      check("init_we", {31'b0, sram_we}, 32'd1);
      check("init_wmask", {31'b0, sram_wmask}, 32'd1);
      check("init_addr", {26'b0, sram_addr}, i);
      check("init_din", sram_din, 32'h0);
      check("init_ready", {30'b0, req_ready}, 32'd0);
      check("init_done_low", {31'b0, init_done}, 32'd0);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    // valid we a0 a1 d0 d1 | ready swe saddr sdin rv rid rdata
    add(2'b11, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b01, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    add(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    add(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, 2'b01, 1'b0, 6'd5, 32'h0, 1'b0, 1'b0, 32'h0);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    add(2'b01, 2'b01, 6'd1, 6'd0, 32'h11, 32'h0, 2'b01, 1'b1, 6'd1, 32'h11, 1'b0, 1'b0, 32'h0);
    add(2'b10, 2'b10, 6'd0, 6'd2, 32'h0, 32'h22, 2'b10, 1'b1, 6'd2, 32'h22, 1'b0, 1'b0, 32'h0);
    add(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 2'b01, 1'b0, 6'd1, 32'h0, 1'b0, 1'b0, 32'h0);
    add(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 2'b10, 1'b0, 6'd2, 32'h0, 1'b1, 1'b0, 32'h11);
    add(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 2'b01, 1'b0, 6'd1, 32'h0, 1'b1, 1'b1, 32'h22);
    add(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 2'b10, 1'b0, 6'd2, 32'h0, 1'b1, 1'b0, 32'h11);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 32'h22);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++)
      add(2'b10, 2'b00, 6'd0, 6'd2, 32'h0, 32'h0, 2'b10, 1'b0, 6'd2, 32'h0,
          (i != 0), 1'b1, (i != 0) ? 32'h22 : 32'h0);
    add(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0, 2'b01, 1'b0, 6'd1, 32'h0, 1'b1, 1'b1, 32'h22);
    add(2'b10, 2'b00, 6'd0, 6'd2, 32'h0, 32'h0, 2'b10, 1'b0, 6'd2, 32'h0, 1'b1, 1'b0, 32'h11);
    add(2'b11, 2'b01, 6'd7, 6'd7, 32'hA5A5A5A5, 32'h0, 2'b01, 1'b1, 6'd7, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h22);
    add(2'b10, 2'b00, 6'd0, 6'd7, 32'h0, 32'h0, 2'b10, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 32'h0);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 32'hA5A5A5A5);
    add(2'b01, 2'b01, 6'd40, 6'd0, 32'h12345678, 32'h0, 2'b01, 1'b1, 6'd40, 32'h12345678, 1'b0, 1'b0, 32'h0);
    add(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 32'h0);

    rst_n = 1'b0;
    drive(2'b11, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
    check("rst_sram_we", {31'b0, sram_we}, 32'd0);
    check("rst_sram_wmask", {31'b0, sram_wmask}, 32'd0);
    check("rst_sram_addr", {26'b0, sram_addr}, 32'd0);
    check("rst_req_ready", {30'b0, req_ready}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    init_fill(64);
    check("fill_done", {31'b0, init_done}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      check($sformatf("v%0d_ready", i), {30'b0, req_ready}, {30'b0, vecs[i].ready});
      check($sformatf("v%0d_sram_we", i), {31'b0, sram_we}, {31'b0, vecs[i].swe});
      check($sformatf("v%0d_sram_wmask", i), {31'b0, sram_wmask}, {31'b0, vecs[i].swe});
      check($sformatf("v%0d_sram_addr", i), {26'b0, sram_addr}, {26'b0, vecs[i].saddr});
      check($sformatf("v%0d_sram_din", i), sram_din, vecs[i].sdin);
      check($sformatf("v%0d_rsp_valid", i), {31'b0, rsp_valid}, {31'b0, vecs[i].rv});
      if (vecs[i].rv) begin
        check($sformatf("v%0d_rsp_id", i), {31'b0, rsp_id}, {31'b0, vecs[i].rid});
        check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].rdata);
      end
      @(negedge clk);
      #1;
    end

    // Reset during RUN with a read response in flight.
    drive(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("inflight_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("inflight_rsp_data", rsp_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    #1;
    check("runrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("runrst_init_done", {31'b0, init_done}, 32'd0);
    check("runrst_sram_we", {31'b0, sram_we}, 32'd0);
    check("runrst_req_ready", {30'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset pulsed at fill cycle 30; fill must restart from address 0.
    init_fill(30);
    rst_n = 1'b0;
    #1;
    check("initrst_init_done", {31'b0, init_done}, 32'd0);
    check("initrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("initrst_sram_we", {31'b0, sram_we}, 32'd0);
    check("initrst_sram_addr", {26'b0, sram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    init_fill(64);
    check("refill_done", {31'b0, init_done}, 32'd1);
    check("refill_rr_reset", {30'b0, req_ready}, 32'd1);
    drive(2'b01, 2'b00, 6'd40, 6'd0, 32'h0, 32'h0);
    #1;
    check("rd40_sram_addr", {26'b0, sram_addr}, 32'd40);
    @(negedge clk);
    #1;
    check("rd40_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd40_rsp_id", {31'b0, rsp_id}, 32'd0);
    check("rd40_rsp_data", rsp_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram22_64x32_arb2.md
Name: sram22_64x32_arb2

Overview:
Two-requester controller for the 64x32 single-port SRAM22 macro (clk, we, wmask, addr, din, dout; one access per cycle; read data 1 cycle after the capturing edge).
- After reset it zero-fills the whole array, because the real macro powers up undefined.
- It then shares the macro between two requesters with round-robin arbitration and valid/ready request handshakes.
- Read responses return with a fixed 1-cycle latency and a requester tag.

Parameters:
DATA_WIDTH, 32, word width; must match macro.
ADDR_WIDTH, 6, address width; depth = 1<<ADDR_WIDTH = 64.
INIT_ZERO, 1, 1 = zero-fill array after reset; 0 = skip fill.

Ports:
clk  in  1  clock, shared with macro
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; a transfer occurs when valid&ready at posedge
req_we  in  2  per-requester 1 = write, 0 = read
req_addr  in  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_din  in  2*DATA_WIDTH  packed write data, same packing
rsp_valid  out  1  read data valid this cycle
rsp_id  out  1  requester owning rsp_data
rsp_data  out  DATA_WIDTH  read data, combinational pass-through of sram_dout
init_done  out  1  high once fill is complete; stays high until reset
sram_we  out  1  to macro we
sram_wmask  out  1  to macro wmask
sram_addr  out  ADDR_WIDTH  to macro addr
sram_din  out  DATA_WIDTH  to macro din
sram_dout  in  DATA_WIDTH  from macro dout

Behaviour:
- Reset (async assert, sync release) clears:
  - state=ST_INIT, or ST_RUN if INIT_ZERO=0; init_addr=0; rr_ptr=0 (requester 0 favoured).
  - rsp_valid=0, rsp_id=0, init_done=0.
  - Combinational SRAM outputs while rst_n=0: sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.
- ST_INIT:
  - Each cycle drives sram_we=1, sram_wmask=1, sram_addr=init_addr, sram_din=0.
  - init_addr increments every cycle.
  - On the edge that writes address 63, goes to ST_RUN and sets init_done=1.
  - Exactly 64 cycles. req_ready=2'b00 throughout.
- INIT_ZERO=0: ST_RUN directly; init_done goes 1 on the first clock edge after reset release.
- ST_RUN arbitration (combinational grant):
  - Only one valid: grant it.
  - Both valid: grant requester rr_ptr.
  - After any grant, rr_ptr becomes the other requester. With no grant, rr_ptr holds.
  - req_ready[g]=1 only for the granted requester. Ready depends on the other requester's valid; requesters must not make valid depend on ready.
- Granted request drives the macro in the same cycle:
  - sram_addr=req_addr[g], sram_din=req_din[g], sram_we=req_we[g], sram_wmask=req_we[g].
  - The macro captures on that posedge (cycle T).
- Read accepted at T:
  - rsp_valid=1 and rsp_id=g during cycle T+1 (registered); rsp_data=sram_dout.
  - A read accepted every cycle yields rsp_valid high every cycle.
- Write: no response. Cycle T+1 has rsp_valid=0; macro dout is X then and is not qualified.
- No grant in ST_RUN: sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0 (idle read of address 0, unqualified).
- Read-after-write to the same address on consecutive cycles returns the new data. The macro is write-then-read across edges; the controller needs no forwarding.
- Writes to the same address on the same cycle are impossible: only one grant per cycle.
- No response backpressure: the consumer must accept rsp_valid every cycle.
- Reset asserted mid-INIT or mid-RUN:
  - Aborts immediately; an in-flight response is dropped (rsp_valid=0).
  - The fill restarts from address 0 after release.
- Address/data widths pass through unchanged; init_addr is ADDR_WIDTH bits plus a terminal-count compare at all-ones.

Decomposition:
- Package sram22_ctrl_pkg:
  - localparams SRAM_DATA_WIDTH=32, SRAM_ADDR_WIDTH=6, SRAM_DEPTH=64.
  - State typedef {ST_INIT, ST_RUN}; requester-id typedef (1 bit).
- Sub-module sram22_rr_arb2: 2-way round-robin arbiter.
  - Ports: clk, rst_n, valid[1:0], advance, grant[1:0], grant_id.
  - advance=1 means "state is ST_RUN".
- Top holds the FSM, the init counter, SRAM muxing and the response register.

Test Plan:
- Reset release, INIT_ZERO=1, both valid held high -> req_ready=0 for 64 cycles; sram_we=1 with addr 0..63 and din=0; init_done rises after the 64th edge; first grant to requester 0 on cycle 65.
- Requester 0 writes addr 5=32'hDEADBEEF, then reads addr 5 next cycle -> rsp_valid=1, rsp_id=0, rsp_data=32'hDEADBEEF one cycle after the read grant.
- Both requesters hold continuous reads (r0 addr 1, r1 addr 2) after preloading 32'h11/32'h22 -> grants alternate 0,1,0,1; rsp stream 32'h11/id0, 32'h22/id1 alternating, no idle cycles.
- Only requester 1 valid for 10 cycles -> req_ready[1]=1 every cycle; after that, simultaneous valid grants requester 0 first (rr_ptr=0).
- Requester 0 writes addr 7=32'hA5A5A5A5 while requester 1 reads addr 7 in the same cycle, rr_ptr=0 -> write granted first; r1 read granted next cycle returns 32'hA5A5A5A5.
- rst_n pulsed low at INIT cycle 30 -> init_done=0, rsp_valid=0 immediately; after release the fill restarts at addr 0 and takes a full 64 cycles; a read of addr 40 afterwards returns 0.
